// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin arbiter and its picker.
package arb_pkg;

    typedef enum logic {IDLE, GRANTED} arb_state_e;

    // Index width that never collapses to zero bits (N==1, MAX_HOLD==0).
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority picker: first set request at or above ptr,
// wrapping back to index 0, found with a single upward scan of a doubled vector.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx,
    output logic [N-1:0]  onehot
);

    // Lower copy keeps only requests at or above ptr; upper copy supplies the wrap.
    logic [2*N-1:0] w_dbl;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dbl
            assign w_dbl[gi]     = req[gi] && (PW'(gi) >= ptr);
            assign w_dbl[gi + N] = req[gi];
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && w_dbl[i]) begin
                found           = 1'b1;
                idx             = PW'(i % N);
                onehot[i % N]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered one-hot grant, round-robin or fixed priority,
// and an optional hold limit that revokes a grant after MAX_HOLD cycles.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 0,
    localparam int PW = clog2_min1(N),
    localparam int HW = clog2_min1(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  request,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_id,
    output logic          busy,
    output logic          timeout
);

    arb_state_e    r_state, w_state_next;
    logic [PW-1:0] r_ptr, w_ptr_next;
    logic [HW-1:0] r_hold, w_hold_next;
    logic [N-1:0]  r_grant, w_grant_next;
    logic [PW-1:0] r_id, w_id_next;
    logic          r_timeout, w_timeout_next;

    logic          w_owner_req;
    logic          w_release;
    logic          w_expire;
    logic [PW-1:0] w_ptr_inc;
    logic [HW-1:0] w_hold_inc;
    logic [PW-1:0] w_pick_ptr;
    logic          w_found;
    logic [PW-1:0] w_idx;
    logic [N-1:0]  w_onehot;

    assign w_owner_req = request[r_id];
    assign w_ptr_inc   = (r_id == PW'(N - 1)) ? '0 : r_id + PW'(1);
    assign w_hold_inc  = (r_hold == HW'(MAX_HOLD)) ? r_hold : r_hold + HW'(1);

    // A release on the same edge as an expiry wins: expiry needs the request still high.
    assign w_release = (r_state == GRANTED) && !w_owner_req;
    assign w_expire  = (MAX_HOLD > 0) && (r_state == GRANTED) && w_owner_req
                       && (w_hold_inc == HW'(MAX_HOLD));

    // The handover pick uses the already-advanced pointer so there is no idle bubble.
    assign w_pick_ptr = w_expire  ? w_ptr_inc :
                        w_release ? ((RR_MODE != 0) ? w_ptr_inc : '0) :
                                    r_ptr;

    rr_pick #(.N(N)) u_pick (
        .req    (request),
        .ptr    (w_pick_ptr),
        .found  (w_found),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_hold_next    = r_hold;
        w_grant_next   = r_grant;
        w_id_next      = r_id;
        w_timeout_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = GRANTED;
                    w_grant_next = w_onehot;
                    w_id_next    = w_idx;
                    w_hold_next  = '0;
                end
            end
            GRANTED: begin
                if (w_release || w_expire) begin
                    w_ptr_next     = w_pick_ptr;
                    w_hold_next    = '0;
                    w_timeout_next = w_expire;
                    if (w_found) begin
                        w_grant_next = w_onehot;
                        w_id_next    = w_idx;
                    end else begin
                        w_state_next = IDLE;
                        w_grant_next = '0;
                        w_id_next    = '0;
                    end
                end else begin
                    w_hold_next = w_hold_inc;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_grant_next = '0;
                w_id_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_grant   <= '0;
            r_id      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_hold    <= w_hold_next;
            r_grant   <= w_grant_next;
            r_id      <= w_id_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_id;
    assign busy     = |r_grant;
    assign timeout  = r_timeout;

endmodule
